pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 3: number of register source ports per instruction (Rn, Rm, Rs).
REQ-002 Parameter REG_AW, default 4: register address width.
REQ-003 Parameter LOAD_LAT, default 1, legal 1..7: load-use stall cycles.
REQ-004 Parameter FWD_EN, default 1: 1 = forwarding mode, 0 = interlock-only mode.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 RA_D  in  NUM_SRC*REG_AW  decode-stage source addresses.
REQ-008 RA_E  in  NUM_SRC*REG_AW  execute-stage source addresses.
REQ-009 WA_E, WA_M, WA_W  in  REG_AW each  destination address per stage.
REQ-010 RegWriteE, RegWriteM, RegWriteW  in  1 each  destination valid per stage.
REQ-011 MemtoRegE  in  1  execute-stage instruction is a load.
REQ-012 PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  stage instruction writes R15.
REQ-013 BranchTakenE  in  1  branch resolved taken in execute.
REQ-014 ForwardE  out  NUM_SRC*2  per source: 00 regfile, 01 from W, 10 from M.
REQ-015 StallF, StallD, FlushD, FlushE  out  1 each  pipeline control.
REQ-016 StallCount  out  32  saturating count of cycles with StallD=1.

Function
REQ-017 Source address all-ones (R15) SHALL never match any destination.
REQ-018 FWD_EN=1: ForwardE[i] SHALL be 10 if RegWriteM and RA_E[i]==WA_M, else 01 if RegWriteW and RA_E[i]==WA_W, else 00; M has priority over W.
REQ-019 FWD_EN=0: ForwardE SHALL be constant 00.
REQ-020 FSM states: RUN, LDSTALL, PCWAIT; RUN is the reset state.
REQ-021 Load-use hit = MemtoRegE and RegWriteE and some RA_D[i]==WA_E; in RUN, a hit SHALL assert StallF, StallD, FlushE in the same cycle (combinational).
REQ-022 On a hit with LOAD_LAT>1, FSM SHALL enter LDSTALL with a down-counter loaded to LOAD_LAT-1; StallF, StallD, FlushE SHALL remain asserted while the counter is non-zero; the FSM SHALL return to RUN when the counter reaches 0.
REQ-023 FWD_EN=0: StallF, StallD, FlushE SHALL assert while any RA_D[i] matches a valid WA_E, WA_M or WA_W.
REQ-024 Any of PCSrcD, PCSrcE or PCSrcM SHALL assert StallF, and the FSM SHALL be in PCWAIT.
REQ-025 FlushD SHALL assert when any PCSrc D/E/M/W is set or BranchTakenE=1.
REQ-026 BranchTakenE SHALL assert FlushE and FlushD, SHALL abort LDSTALL (counter cleared, next state RUN) and SHALL suppress StallD that cycle.
REQ-027 FSM priority when events coincide: BranchTakenE > PC write > load-use.
REQ-028 PCWAIT SHALL return to RUN in the cycle after PCSrcW is seen and no PCSrc D/E/M remains set.
REQ-029 StallD and FlushD SHALL never both be 1; FlushD wins.
REQ-030 StallCount SHALL increment by 1 per cycle with StallD=1 and SHALL hold at 0xFFFFFFFF.

Reset
REQ-031 Reset SHALL force FSM to RUN, the load counter to 0 and StallCount to 0, asynchronously.
REQ-032 During reset, StallF, StallD, FlushD and FlushE SHALL be 0 and ForwardE SHALL be 00.
REQ-033 Reset asserted mid-LDSTALL SHALL drop the stall in the same cycle, with no residual stall after release.

Structure
REQ-034 A shared package SHALL hold FSM state encodings, the ForwardE codes (00/01/10) and the R15 address constant.
REQ-035 One sub-module, hazard_match, SHALL compare one source address against E/M/W destinations; it SHALL be instantiated NUM_SRC times per stage group.

Verification
REQ-036 RegWriteM=1, WA_M=3, RegWriteW=1, WA_W=3, RA_E[0]=3 -> ForwardE[0]=10.
REQ-037 Load to R2 in E, RA_D[1]=2, LOAD_LAT=3 -> StallD=1 for exactly 3 cycles, StallCount=3.
REQ-038 BranchTakenE during the 2nd LDSTALL cycle -> FlushD=FlushE=1, StallD=0, FSM RUN next cycle.
REQ-039 PCSrcD pulse flowing D->W -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles, then RUN.
REQ-040 FWD_EN=0, RegWriteW=1, WA_W=5, RA_D[2]=5 -> stall asserted; RA_D[2]=15 with WA_W=15 -> no stall.
REQ-041 reset low mid-LDSTALL -> all stalls 0 immediately, StallCount=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_hazard_ctrl_pkg
//  Purpose : Shared definitions for the pipeline hazard controller: FSM state
//            encodings, ForwardE select codes, the PC (R15) address constant
//            and a small forwarding-priority helper.
//  Ports   : (package - none)
//  Rev     : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  // Hazard controller FSM states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_PCWAIT  = 2'd2
  } hz_state_t;

  // ForwardE codes for one source operand
  localparam logic [1:0] c_FWD_RF = 2'b00;   // operand from register file
  localparam logic [1:0] c_FWD_W  = 2'b01;   // operand from writeback result
  localparam logic [1:0] c_FWD_M  = 2'b10;   // operand from memory-stage result

  // The PC register is the all-ones address; modules slice this to REG_AW
  localparam logic [31:0] c_R15_ALL_ONES = 32'hFFFF_FFFF;

  // Width of the load-use down-counter (LOAD_LAT is at most 7)
  localparam int unsigned c_LDCNT_W = 3;

  // M-stage result is younger than W-stage, so it takes priority
  function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
    logic [1:0] sel;
    sel = c_FWD_RF;
    if (hit_m) begin
      sel = c_FWD_M;
    end else if (hit_w) begin
      sel = c_FWD_W;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_match
//  Purpose : Compares one source register address against the destination
//            addresses of the E, M and W stages. A hit requires the stage's
//            write-enable and is never reported for the PC (all-ones) address.
//  Ports   : i_ra                 source address
//            i_wa_e/i_wa_m/i_wa_w destination address per stage
//            i_we_e/i_we_m/i_we_w destination valid per stage
//            o_hit_e/o_hit_m/o_hit_w  per-stage match flags
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_wa_e,
  input  logic [REG_AW-1:0] i_wa_m,
  input  logic [REG_AW-1:0] i_wa_w,
  input  logic              i_we_e,
  input  logic              i_we_m,
  input  logic              i_we_w,
  output logic              o_hit_e,
  output logic              o_hit_m,
  output logic              o_hit_w
);

  localparam logic [REG_AW-1:0] c_PC_ADDR = c_R15_ALL_ONES[REG_AW-1:0];

  // PC reads are supplied by the fetch path, never by a hazard bypass
  logic w_src_ok;
  assign w_src_ok = (i_ra != c_PC_ADDR);

  assign o_hit_e = w_src_ok & i_we_e & (i_ra == i_wa_e);
  assign o_hit_m = w_src_ok & i_we_m & (i_ra == i_wa_m);
  assign o_hit_w = w_src_ok & i_we_w & (i_ra == i_wa_w);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_hazard_ctrl
//  Purpose : Hazard unit for a 5-stage pipeline. Generates operand forwarding
//            selects, load-use / interlock stalls, PC-write fetch stalls and
//            branch / PC-write flushes, and counts decode-stall cycles.
//  Ports   : clk          clock, rising edge
//            reset        asynchronous active-low reset
//            RA_D / RA_E  packed source addresses, decode / execute stage
//            WA_E/M/W     destination address per stage
//            RegWriteE/M/W destination valid per stage
//            MemtoRegE    execute-stage instruction is a load
//            PCSrcD/E/M/W stage instruction writes the PC
//            BranchTakenE branch resolved taken in execute
//            ForwardE     2-bit forward select per source (00 RF, 01 W, 10 M)
//            StallF/StallD/FlushD/FlushE  pipeline control
//            StallCount   saturating count of StallD cycles
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int REG_AW   = 4,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] RA_D,
  input  logic [NUM_SRC*REG_AW-1:0] RA_E,
  input  logic [REG_AW-1:0]         WA_E,
  input  logic [REG_AW-1:0]         WA_M,
  input  logic [REG_AW-1:0]         WA_W,
  input  logic                      RegWriteE,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      MemtoRegE,
  input  logic                      PCSrcD,
  input  logic                      PCSrcE,
  input  logic                      PCSrcM,
  input  logic                      PCSrcW,
  input  logic                      BranchTakenE,
  output logic [NUM_SRC*2-1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [31:0]               StallCount
);

  localparam logic [c_LDCNT_W-1:0] c_LD_INIT = c_LDCNT_W'(LOAD_LAT - 1);

  // --------------------------------------------------------------------------
  // Address comparators: one per source for the decode group and one per
  // source for the execute group.
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] w_d_hit_e;
  logic [NUM_SRC-1:0] w_d_hit_m;
  logic [NUM_SRC-1:0] w_d_hit_w;
  logic [NUM_SRC-1:0] w_e_hit_m;
  logic [NUM_SRC-1:0] w_e_hit_w;
  logic [NUM_SRC-1:0] w_unused_e_hit_e;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_match #(
      .REG_AW (REG_AW)
    ) u_match_d (
      .i_ra    (RA_D[gi*REG_AW +: REG_AW]),
      .i_wa_e  (WA_E),
      .i_wa_m  (WA_M),
      .i_wa_w  (WA_W),
      .i_we_e  (RegWriteE),
      .i_we_m  (RegWriteM),
      .i_we_w  (RegWriteW),
      .o_hit_e (w_d_hit_e[gi]),
      .o_hit_m (w_d_hit_m[gi]),
      .o_hit_w (w_d_hit_w[gi])
    );

    hazard_match #(
      .REG_AW (REG_AW)
    ) u_match_e (
      .i_ra    (RA_E[gi*REG_AW +: REG_AW]),
      .i_wa_e  (WA_E),
      .i_wa_m  (WA_M),
      .i_wa_w  (WA_W),
      .i_we_e  (RegWriteE),
      .i_we_m  (RegWriteM),
      .i_we_w  (RegWriteW),
      .o_hit_e (w_unused_e_hit_e[gi]),
      .o_hit_m (w_e_hit_m[gi]),
      .o_hit_w (w_e_hit_w[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Forwarding selects
  // --------------------------------------------------------------------------
  logic [NUM_SRC*2-1:0] w_fwd;

  if (FWD_EN != 0) begin : g_fwd
    always_comb begin
      w_fwd = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        w_fwd[2*i +: 2] = fwd_select(w_e_hit_m[i], w_e_hit_w[i]);
      end
    end
  end else begin : g_nofwd
    // Interlock-only: operands always come from the register file
    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_e_hit_m, w_e_hit_w};
    assign w_fwd        = '0;
  end

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  hz_state_t            r_state;
  logic [c_LDCNT_W-1:0] r_ld_cnt;
  logic [31:0]          r_stall_cnt;

  logic w_ld_hit;      // load in E feeds a source in D
  logic w_interlock;   // any RAW dependency, used when there is no bypass
  logic w_ld_active;   // extra load-latency cycles still pending
  logic w_ld_stall;    // combined data-hazard stall request
  logic w_pc_dem;      // PC write still in flight ahead of writeback
  logic w_pc_any;
  logic w_flush_d;
  logic w_stall_d;

  assign w_ld_hit    = MemtoRegE & (|w_d_hit_e);
  assign w_interlock = (FWD_EN == 0) ? (|(w_d_hit_e | w_d_hit_m | w_d_hit_w)) : 1'b0;
  assign w_ld_active = (r_state == ST_LDSTALL) && (r_ld_cnt != '0);

  // A taken branch squashes the dependent instruction, so no stall is needed
  assign w_ld_stall  = (w_ld_hit | w_ld_active | w_interlock) & ~BranchTakenE;

  assign w_pc_dem    = PCSrcD | PCSrcE | PCSrcM;
  assign w_pc_any    = w_pc_dem | PCSrcW;
  assign w_flush_d   = w_pc_any | BranchTakenE;

  // Flushing D dominates stalling it: the stalled instruction is discarded
  assign w_stall_d   = w_ld_stall & ~w_flush_d;

  // Outputs are forced quiet while reset is held, independent of the inputs
  assign StallF      = reset & (w_ld_stall | w_pc_dem);
  assign StallD      = reset & w_stall_d;
  assign FlushD      = reset & w_flush_d;
  assign FlushE      = reset & (w_ld_stall | BranchTakenE);
  assign ForwardE    = reset ? w_fwd : '0;
  assign StallCount  = r_stall_cnt;

  // --------------------------------------------------------------------------
  // Control FSM: branch > PC write > load-use
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_ld_cnt <= '0;
    end else if (BranchTakenE) begin
      r_state  <= ST_RUN;
      r_ld_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_pc_dem) begin
            r_state <= ST_PCWAIT;
          end else if (w_ld_hit && (LOAD_LAT > 1)) begin
            r_state  <= ST_LDSTALL;
            r_ld_cnt <= c_LD_INIT;
          end
        end
        ST_LDSTALL: begin
          if (w_pc_dem) begin
            r_state  <= ST_PCWAIT;
            r_ld_cnt <= '0;
          end else if (r_ld_cnt <= c_LDCNT_W'(1)) begin
            r_state  <= ST_RUN;
            r_ld_cnt <= '0;
          end else begin
            r_ld_cnt <= r_ld_cnt - c_LDCNT_W'(1);
          end
        end
        ST_PCWAIT: begin
          // Leave once the PC write has retired and nothing newer follows it
          if (PCSrcW && !w_pc_dem) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_ld_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating decode-stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_d && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipe_hazard_ctrl
//  Purpose : Self-checking bench for pipe_hazard_ctrl. Two instances share the
//            stimulus: index 0 forwarding with LOAD_LAT=3, index 1
//            interlock-only with LOAD_LAT=1.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] ra_d, ra_e;
  logic [3:0]  wa_e, wa_m, wa_w;
  logic        rwe, rwm, rww, m2r, pcd, pce, pcm, pcsw, bt;

  logic [5:0]  fwd_o  [2];
  logic [1:0]  sf_o, sd_o, fd_o, fe_o;
  logic [31:0] scnt_o [2];

  int n_pass  = 0;
  int n_total = 0;

  pipe_hazard_ctrl #(.NUM_SRC(3), .REG_AW(4), .LOAD_LAT(3), .FWD_EN(1)) u_fwd (
    .clk(clk), .reset(rst_n), .RA_D(ra_d), .RA_E(ra_e),
    .WA_E(wa_e), .WA_M(wa_m), .WA_W(wa_w),
    .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww), .MemtoRegE(m2r),
    .PCSrcD(pcd), .PCSrcE(pce), .PCSrcM(pcm), .PCSrcW(pcsw), .BranchTakenE(bt),
    .ForwardE(fwd_o[0]), .StallF(sf_o[0]), .StallD(sd_o[0]), .FlushD(fd_o[0]),
    .FlushE(fe_o[0]), .StallCount(scnt_o[0])
  );

  pipe_hazard_ctrl #(.NUM_SRC(3), .REG_AW(4), .LOAD_LAT(1), .FWD_EN(0)) u_il (
    .clk(clk), .reset(rst_n), .RA_D(ra_d), .RA_E(ra_e),
    .WA_E(wa_e), .WA_M(wa_m), .WA_W(wa_w),
    .RegWriteE(rwe), .RegWriteM(rwm), .RegWriteW(rww), .MemtoRegE(m2r),
    .PCSrcD(pcd), .PCSrcE(pce), .PCSrcM(pcm), .PCSrcW(pcsw), .BranchTakenE(bt),
    .ForwardE(fwd_o[1]), .StallF(sf_o[1]), .StallD(sd_o[1]), .FlushD(fd_o[1]),
    .FlushE(fe_o[1]), .StallCount(scnt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle();
    ra_d = 12'hFFF; ra_e = 12'hFFF;
    wa_e = 4'h0; wa_m = 4'h0; wa_w = 4'h0;
    {rwe, rwm, rww, m2r, pcd, pce, pcm, pcsw, bt} = '0;
  endtask

  // Load into R2 in E with decode source 1 reading R2
  task automatic load_hit();
    idle();
    m2r = 1'b1; rwe = 1'b1; wa_e = 4'h2; ra_d = 12'hF2F;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: rules applied directly to the current inputs, with the
  // pipeline memory kept as "load cycles still owed" and "PC write pending".
  // --------------------------------------------------------------------------
  int          m_fwden [2] = '{1, 0};
  int          m_lat   [2] = '{3, 1};
  int          m_ld_rem[2];
  bit          m_pcw   [2];
  logic [31:0] m_scnt  [2];

  typedef struct packed {
    logic [5:0] fwd;
    logic sf, sd, fd, fe;
  } outs_t;

  function automatic bit dep(input logic [3:0] ra, input logic [3:0] wa, input logic we);
    return we && (ra == wa) && (ra != 4'hF);
  endfunction

  function automatic bit load_use();
    bit h = 1'b0;
    for (int i = 0; i < 3; i++) if (m2r && dep(ra_d[4*i +: 4], wa_e, rwe)) h = 1'b1;
    return h;
  endfunction

  function automatic outs_t model_out(input int k);
    outs_t o;
    bit any_dep, ld;
    o = '0;
    any_dep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_fwden[k] != 0) begin
        if (dep(ra_e[4*i +: 4], wa_m, rwm))      o.fwd[2*i +: 2] = 2'b10;
        else if (dep(ra_e[4*i +: 4], wa_w, rww)) o.fwd[2*i +: 2] = 2'b01;
      end
      if (dep(ra_d[4*i +: 4], wa_e, rwe) || dep(ra_d[4*i +: 4], wa_m, rwm) ||
          dep(ra_d[4*i +: 4], wa_w, rww)) any_dep = 1'b1;
    end
    ld = (load_use() || (m_ld_rem[k] > 0) || (m_fwden[k] == 0 && any_dep)) && !bt;
    o.fd = pcd || pce || pcm || pcsw || bt;
    o.sf = ld || pcd || pce || pcm;
    o.sd = ld && !o.fd;
    o.fe = ld || bt;
    return o;
  endfunction

  task automatic model_step(input int k, input logic sd);
    bit pdem;
    pdem = pcd || pce || pcm;
    if (sd && m_scnt[k] != 32'hFFFF_FFFF) m_scnt[k] = m_scnt[k] + 1;
    if (bt) begin
      m_ld_rem[k] = 0; m_pcw[k] = 1'b0;
    end else if (m_ld_rem[k] > 0) begin
      if (pdem) begin m_pcw[k] = 1'b1; m_ld_rem[k] = 0; end
      else m_ld_rem[k] = m_ld_rem[k] - 1;
    end else if (m_pcw[k]) begin
      if (pcsw && !pdem) m_pcw[k] = 1'b0;
    end else if (pdem) begin
      m_pcw[k] = 1'b1;
    end else if (load_use() && m_lat[k] > 1) begin
      m_ld_rem[k] = m_lat[k] - 1;
    end
  endtask

  function automatic logic [3:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 4'hF : 4'(r % 4);
  endfunction

  // --------------------------------------------------------------------------
  // Combinational vector table (no loads, no PC writes: FSMs stay in RUN)
  // --------------------------------------------------------------------------
  typedef struct {
    logic [11:0] ra_d, ra_e;
    logic [3:0]  wa_e, wa_m, wa_w;
    logic        rwe, rwm, rww;
    logic [5:0]  e_fwd;
    logic        e_il_stall;
    logic        e_fw_stall;
  } vec_t;

  vec_t vt [8];

  initial begin
    outs_t eo;

    vt[0] = '{12'hFFF, 12'h003, 4'h0, 4'h3, 4'h3, 1'b0, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b0};
    vt[1] = '{12'hFFF, 12'h431, 4'h0, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1, 6'b010000, 1'b0, 1'b0};
    vt[2] = '{12'h000, 12'h277, 4'h0, 4'h7, 4'h2, 1'b0, 1'b1, 1'b1, 6'b011010, 1'b0, 1'b0};
    vt[3] = '{12'hF00, 12'hFFF, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 6'b000000, 1'b0, 1'b0};
    vt[4] = '{12'h500, 12'h000, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0};
    vt[5] = '{12'h060, 12'h000, 4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0};
    vt[6] = '{12'h009, 12'h999, 4'h0, 4'h9, 4'h0, 1'b0, 1'b1, 1'b0, 6'b101010, 1'b1, 1'b0};
    vt[7] = '{12'h555, 12'h555, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0};

    // Reset state: outputs quiet and counters cleared while reset is held
    idle();
    rwm = 1'b1; wa_m = 4'h3; ra_e = 12'h003; pcd = 1'b1; m2r = 1'b1; rwe = 1'b1;
    wa_e = 4'h2; ra_d = 12'hF2F;
    rst_n = 1'b0;
    #3;
    chk("reset_fwd",    {26'd0, fwd_o[0]}, 32'h0);
    chk("reset_stallF", {31'd0, sf_o[0]},  32'h0);
    chk("reset_stallD", {31'd0, sd_o[1]},  32'h0);
    chk("reset_flushD", {31'd0, fd_o[0]},  32'h0);
    chk("reset_flushE", {31'd0, fe_o[0]},  32'h0);
    chk("reset_scnt",   scnt_o[0],         32'h0);
    do_reset();

    for (int v = 0; v < 8; v++) begin
      idle();
      ra_d = vt[v].ra_d; ra_e = vt[v].ra_e;
      wa_e = vt[v].wa_e; wa_m = vt[v].wa_m; wa_w = vt[v].wa_w;
      rwe = vt[v].rwe; rwm = vt[v].rwm; rww = vt[v].rww;
      @(negedge clk);
      chk($sformatf("vec%0d_fwd", v),      {26'd0, fwd_o[0]}, {26'd0, vt[v].e_fwd});
      chk($sformatf("vec%0d_il_fwd", v),   {26'd0, fwd_o[1]}, 32'h0);
      chk($sformatf("vec%0d_il_stallD", v), {31'd0, sd_o[1]}, {31'd0, vt[v].e_il_stall});
      chk($sformatf("vec%0d_fw_stallD", v), {31'd0, sd_o[0]}, {31'd0, vt[v].e_fw_stall});
      next_cycle();
    end

    // Load-use with LOAD_LAT=3: three stall cycles, counter reaches 3
    do_reset();
    load_hit();
    @(negedge clk);
    chk("ld_c0_stallD", {31'd0, sd_o[0]}, 32'h1);
    chk("ld_c0_stallF", {31'd0, sf_o[0]}, 32'h1);
    chk("ld_c0_flushE", {31'd0, fe_o[0]}, 32'h1);
    next_cycle(); idle(); ra_d = 12'hF2F;
    @(negedge clk); chk("ld_c1_stallD", {31'd0, sd_o[0]}, 32'h1);
    next_cycle();
    @(negedge clk); chk("ld_c2_stallD", {31'd0, sd_o[0]}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("ld_c3_stallD", {31'd0, sd_o[0]}, 32'h0);
    chk("ld_c3_scnt",   scnt_o[0],        32'd3);
    next_cycle();

    // Branch taken during the load stall aborts it
    idle(); next_cycle();
    load_hit();
    @(negedge clk); chk("br_c0_stallD", {31'd0, sd_o[0]}, 32'h1);
    next_cycle(); idle(); bt = 1'b1;
    @(negedge clk);
    chk("br_c1_flushD", {31'd0, fd_o[0]}, 32'h1);
    chk("br_c1_flushE", {31'd0, fe_o[0]}, 32'h1);
    chk("br_c1_stallD", {31'd0, sd_o[0]}, 32'h0);
    next_cycle(); idle();
    @(negedge clk);
    chk("br_c2_stallD", {31'd0, sd_o[0]}, 32'h0);
    chk("br_c2_stallF", {31'd0, sf_o[0]}, 32'h0);
    chk("br_c2_flushE", {31'd0, fe_o[0]}, 32'h0);
    next_cycle();

    // PC write flowing D->E->M->W
    for (int c = 0; c < 5; c++) begin
      idle();
      pcd = (c == 0); pce = (c == 1); pcm = (c == 2); pcsw = (c == 3);
      @(negedge clk);
      chk($sformatf("pc_c%0d_stallF", c), {31'd0, sf_o[0]}, {31'd0, c < 3});
      chk($sformatf("pc_c%0d_flushD", c), {31'd0, fd_o[0]}, {31'd0, c < 4});
      chk($sformatf("pc_c%0d_stallD", c), {31'd0, sd_o[0]}, 32'h0);
      next_cycle();
    end
    // Back in RUN: a fresh load-use must open a multi-cycle stall
    load_hit(); next_cycle(); idle();
    @(negedge clk); chk("pc_run_ldstall", {31'd0, sd_o[0]}, 32'h1);
    repeat (3) next_cycle();

    // Reset asserted in the middle of a load stall
    do_reset();
    load_hit(); next_cycle();
    idle(); rwm = 1'b1; wa_m = 4'h3; ra_e = 12'h003;
    @(negedge clk);
    chk("rst_mid_pre_stallD", {31'd0, sd_o[0]},  32'h1);
    chk("rst_mid_pre_fwd",    {26'd0, fwd_o[0]}, 32'h2);
    #1 rst_n = 1'b0; pcd = 1'b1;
    #1;
    chk("rst_mid_stallD", {31'd0, sd_o[0]},  32'h0);
    chk("rst_mid_stallF", {31'd0, sf_o[0]},  32'h0);
    chk("rst_mid_flushE", {31'd0, fe_o[0]},  32'h0);
    chk("rst_mid_flushD", {31'd0, fd_o[0]},  32'h0);
    chk("rst_mid_fwd",    {26'd0, fwd_o[0]}, 32'h0);
    chk("rst_mid_scnt",   scnt_o[0],         32'h0);
    @(posedge clk); #2;
    idle(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_stallD", {31'd0, sd_o[0]}, 32'h0);
    chk("rst_rel_stallF", {31'd0, sf_o[0]}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rst_rel2_stallD", {31'd0, sd_o[0]}, 32'h0);
    next_cycle();

    // Randomized stimulus against the reference model
    do_reset();
    for (int k = 0; k < 2; k++) begin
      m_ld_rem[k] = 0; m_pcw[k] = 1'b0; m_scnt[k] = 32'h0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 3; i++) begin
        ra_d[4*i +: 4] = rnd_addr();
        ra_e[4*i +: 4] = rnd_addr();
      end
      wa_e = rnd_addr(); wa_m = rnd_addr(); wa_w = rnd_addr();
      rwe  = ($urandom_range(0, 3) != 0);
      rwm  = ($urandom_range(0, 1) != 0);
      rww  = ($urandom_range(0, 1) != 0);
      m2r  = ($urandom_range(0, 2) == 0);
      pcd  = ($urandom_range(0, 15) == 0);
      pce  = ($urandom_range(0, 15) == 0);
      pcm  = ($urandom_range(0, 15) == 0);
      pcsw = ($urandom_range(0, 7) == 0);
      bt   = ($urandom_range(0, 11) == 0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eo = model_out(k);
        chk($sformatf("rnd%0d_u%0d_fwd", c, k),    {26'd0, fwd_o[k]}, {26'd0, eo.fwd});
        chk($sformatf("rnd%0d_u%0d_stallF", c, k), {31'd0, sf_o[k]},  {31'd0, eo.sf});
        chk($sformatf("rnd%0d_u%0d_stallD", c, k), {31'd0, sd_o[k]},  {31'd0, eo.sd});
        chk($sformatf("rnd%0d_u%0d_flushD", c, k), {31'd0, fd_o[k]},  {31'd0, eo.fd});
        chk($sformatf("rnd%0d_u%0d_flushE", c, k), {31'd0, fe_o[k]},  {31'd0, eo.fe});
        chk($sformatf("rnd%0d_u%0d_scnt", c, k),   scnt_o[k],         m_scnt[k]);
        model_step(k, eo.sd);
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
